// File: rtl/biu_constants_pkg.sv
// Bus-interface constants shared by the MMU, BIU and memory responder:
// access sizes plus byte-enable and alignment helpers.
package biu_constants_pkg;

    typedef enum logic [2:0] {
        BYTE  = 3'd0,
        HWORD = 3'd1,
        WORD  = 3'd2,
        DWORD = 3'd3,
        QWORD = 3'd4
    } biu_size_t;

    function automatic logic [3:0] biu_be(input biu_size_t size,
                                          input logic [1:0] adr);
        logic [3:0] be;
        be = 4'b0000;
        case (size)
            BYTE:    be = 4'b0001 << adr;
            HWORD:   be = adr[1] ? 4'b1100 : 4'b0011;
            WORD:    be = 4'b1111;
            default: be = 4'b0000;
        endcase
        return be;
    endfunction

    // Sizes wider than the 32-bit data path always count as misaligned.
    function automatic logic biu_misaligned(input biu_size_t size,
                                            input logic [1:0] adr);
        logic bad;
        bad = 1'b1;
        case (size)
            BYTE:    bad = 1'b0;
            HWORD:   bad = adr[0];
            WORD:    bad = (adr != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/riscv_memresp_ram.sv
// Single-port word RAM with per-byte write enables and a registered read.
// No reset: contents survive rst_i.
module riscv_memresp_ram #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 1024,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              re,
    input  logic [XLEN/8-1:0] be,
    input  logic [AW-1:0]     addr,
    input  logic [XLEN-1:0]   wdata,
    output logic [XLEN-1:0]   rdata
);

    logic [XLEN-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        for (int b = 0; b < XLEN / 8; b++) begin
            if (be[b]) begin
                mem[addr][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
        if (re) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/riscv_mem_responder.sv
// Physical-bus memory responder: one request at a time, fixed wait states.
// Define RV_MEMRESP_CLEAR_EN to zero the RAM after every reset.
module riscv_mem_responder
    import biu_constants_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int PLEN        = 32,
    parameter int DEPTH       = 1024,
    parameter int WAIT_STATES = 2
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            preq_i,
    input  logic [PLEN-1:0] padr_i,
    input  biu_size_t       psize_i,
    input  logic            plock_i,
    input  logic            pwe_i,
    input  logic [XLEN-1:0] pd_i,
    output logic [XLEN-1:0] pq_o,
    output logic            pack_o,
    output logic            perr_o,
    output logic            plocked_o,
    output logic            busy_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [PLEN:0] LIMIT = (PLEN+1)'(DEPTH * 4);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_ACK  = 2'd2;
`ifdef RV_MEMRESP_CLEAR_EN
    localparam logic [1:0] S_CLEAR = 2'd3;
    localparam logic [1:0] S_RESET = S_CLEAR;
    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);
`else
    localparam logic [1:0] S_RESET = S_IDLE;
`endif

    logic [1:0]      state;
    logic [3:0]      wcnt;
    logic [AW-1:0]   idx_q;
    logic [1:0]      lo_q;
    biu_size_t       size_q;
    logic            we_q;
    logic            err_q;
    logic [XLEN-1:0] d_q;

    logic            accept;
    logic            err_in;
    logic [AW-1:0]   idx_in;
    logic            rd_issue;
    logic [AW-1:0]   ram_addr;
    logic [3:0]      ram_be;
    logic [XLEN-1:0] ram_wdata;
    logic [XLEN-1:0] ram_rdata;

    assign accept = (state == S_IDLE) && preq_i;
    assign idx_in = padr_i[AW+1:2];
    assign err_in = biu_misaligned(psize_i, padr_i[1:0])
                 || ({1'b0, padr_i} >= LIMIT);

    // The read lands in the RAM output register just as ACK begins.
    assign rd_issue = ((state == S_WAIT) && (wcnt == 4'd1))
                   || (accept && (WAIT_STATES == 0));

`ifdef RV_MEMRESP_CLEAR_EN
    logic [AW-1:0] clr_idx;

    always_comb begin
        ram_addr  = accept ? idx_in : idx_q;
        ram_be    = 4'b0000;
        ram_wdata = d_q;
        if (state == S_CLEAR) begin
            ram_addr  = clr_idx;
            ram_be    = 4'b1111;
            ram_wdata = '0;
        end else if (state == S_ACK && we_q && !err_q) begin
            ram_be = biu_be(size_q, lo_q);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            clr_idx <= '0;
        end else if (state == S_CLEAR && clr_idx != LAST) begin
            clr_idx <= clr_idx + 1'b1;
        end
    end
`else
    always_comb begin
        ram_addr  = accept ? idx_in : idx_q;
        ram_be    = 4'b0000;
        ram_wdata = d_q;
        if (state == S_ACK && we_q && !err_q) begin
            ram_be = biu_be(size_q, lo_q);
        end
    end
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state     <= S_RESET;
            wcnt      <= 4'd0;
            idx_q     <= '0;
            lo_q      <= 2'b00;
            size_q    <= BYTE;
            we_q      <= 1'b0;
            err_q     <= 1'b0;
            d_q       <= '0;
            plocked_o <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (preq_i) begin
                        idx_q     <= idx_in;
                        lo_q      <= padr_i[1:0];
                        size_q    <= psize_i;
                        we_q      <= pwe_i;
                        err_q     <= err_in;
                        d_q       <= pd_i;
                        plocked_o <= plock_i;
                        wcnt      <= 4'(WAIT_STATES);
                        state     <= (WAIT_STATES > 0) ? S_WAIT : S_ACK;
                    end
                end
                S_WAIT: begin
                    if (wcnt <= 4'd1) begin
                        state <= S_ACK;
                    end else begin
                        wcnt <= wcnt - 4'd1;
                    end
                end
                S_ACK: begin
                    state <= S_IDLE;
                end
`ifdef RV_MEMRESP_CLEAR_EN
                S_CLEAR: begin
                    if (clr_idx == LAST) begin
                        state <= S_IDLE;
                    end
                end
`endif
                default: state <= S_IDLE;
            endcase
        end
    end

    riscv_memresp_ram #(
        .XLEN  (XLEN),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk   (clk_i),
        .re    (rd_issue),
        .be    (ram_be),
        .addr  (ram_addr),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );

    assign pack_o = (state == S_ACK);
    assign perr_o = (state == S_ACK) && err_q;
    assign pq_o   = (state == S_ACK && !we_q && !err_q) ? ram_rdata : '0;
    assign busy_o = (state != S_IDLE);

endmodule

// File: tb/tb_riscv_mem_responder.sv
// Directed-vector bench for riscv_mem_responder (WAIT_STATES=2).
// With RV_MEMRESP_CLEAR_EN the RAM is shrunk to 16 words to exercise the clear.
module tb_riscv_mem_responder;
    import biu_constants_pkg::*;

`ifdef RV_MEMRESP_CLEAR_EN
    localparam int DEPTH = 16;
    localparam bit CLR = 1'b1;
`else
    localparam int DEPTH = 1024;
    localparam bit CLR = 1'b0;
`endif
    localparam int WS = 2;
    localparam logic [31:0] TOP = DEPTH * 4;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        preq_i;
    logic [31:0] padr_i;
    biu_size_t   psize_i;
    logic        plock_i;
    logic        pwe_i;
    logic [31:0] pd_i;
    logic [31:0] pq_o;
    logic        pack_o;
    logic        perr_o;
    logic        plocked_o;
    logic        busy_o;

    int vectors = 0;
    int miscompares = 0;

    riscv_mem_responder #(
        .XLEN        (32),
        .PLEN        (32),
        .DEPTH       (DEPTH),
        .WAIT_STATES (WS)
    ) dut (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .preq_i    (preq_i),
        .padr_i    (padr_i),
        .psize_i   (psize_i),
        .plock_i   (plock_i),
        .pwe_i     (pwe_i),
        .pd_i      (pd_i),
        .pq_o      (pq_o),
        .pack_o    (pack_o),
        .perr_o    (perr_o),
        .plocked_o (plocked_o),
        .busy_o    (busy_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Starts at a negedge with the DUT idle; lat counts edges from
    // raising preq_i to the cycle in which pack_o is seen (0 = timeout).
    task automatic xact(input logic [31:0] adr, input biu_size_t sz,
                        input logic we, input logic [31:0] d,
                        input logic lk, input bit chg,
                        output logic [31:0] q, output logic err,
                        output int lat);
        padr_i  = adr;
        psize_i = sz;
        pwe_i   = we;
        pd_i    = d;
        plock_i = lk;
        preq_i  = 1'b1;
        lat = 0;
        q   = 32'h0;
        err = 1'b0;
        for (int i = 1; i <= 200; i++) begin
            @(posedge clk_i);
            @(negedge clk_i);
            if (chg && i == 1) begin
                padr_i  = 32'h20;
                pwe_i   = 1'b1;
                pd_i    = 32'h0;
                psize_i = WORD;
            end
            if (pack_o) begin
                lat = i;
                q   = pq_o;
                err = perr_o;
                break;
            end
        end
        preq_i = 1'b0;
        @(negedge clk_i);
    endtask

    task automatic op(input string tag, input logic [31:0] adr,
                      input biu_size_t sz, input logic we,
                      input logic [31:0] d, input logic lk, input bit chg,
                      input logic [31:0] eq, input logic eerr);
        logic [31:0] q;
        logic        err;
        int          lat;
        xact(adr, sz, we, d, lk, chg, q, err, lat);
        check({tag, ".lat"}, 32'(lat), 32'(WS + 1));
        check({tag, ".pq"}, q, eq);
        check({tag, ".perr"}, {31'b0, err}, {31'b0, eerr});
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (busy_o && n < 200) begin
            @(negedge clk_i);
            n++;
        end
        check({tag, ".idle"}, {31'b0, busy_o}, 32'h0);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] q;
        logic        err;
        int          lat;
        int          n;
        int          seen;

        rst_i   = 1'b1;
        preq_i  = 1'b0;
        padr_i  = 32'h0;
        psize_i = BYTE;
        plock_i = 1'b0;
        pwe_i   = 1'b0;
        pd_i    = 32'h0;
        repeat (2) @(negedge clk_i);
        check("rst.pack", {31'b0, pack_o}, 32'h0);
        check("rst.perr", {31'b0, perr_o}, 32'h0);
        check("rst.pq", pq_o, 32'h0);
        check("rst.plocked", {31'b0, plocked_o}, 32'h0);
        check("rst.busy", {31'b0, busy_o}, {31'b0, CLR});

        rst_i = 1'b0;
        #1;
        n = 0;
        while (busy_o && n < 200) begin
            @(negedge clk_i);
            n++;
        end
        check("clr.cycles", 32'(n), CLR ? 32'(DEPTH) : 32'h0);
        @(negedge clk_i);

        op("wr10", 32'h10, WORD, 1, 32'hDEADBEEF, 0, 0, 32'h0, 0);
        op("rd10", 32'h10, WORD, 0, 32'h0, 0, 0, 32'hDEADBEEF, 0);
        op("wr10b", 32'h10, WORD, 1, 32'h11223344, 0, 0, 32'h0, 0);
        op("wrb12", 32'h12, BYTE, 1, 32'h00AA0000, 0, 0, 32'h0, 0);
        op("rd10b", 32'h10, WORD, 0, 32'h0, 0, 0, 32'h11AA3344, 0);
        op("wr20", 32'h20, WORD, 1, 32'h55667788, 0, 0, 32'h0, 0);
        op("wrh21", 32'h21, HWORD, 1, 32'hFFFF0000, 0, 0, 32'h0, 1);
        op("rd20", 32'h20, WORD, 0, 32'h0, 0, 0, 32'h55667788, 0);
        op("wrh22", 32'h22, HWORD, 1, 32'hBEEF0000, 0, 0, 32'h0, 0);
        op("rd20b", 32'h20, WORD, 0, 32'h0, 0, 0, 32'hBEEF7788, 0);
        op("wrb20", 32'h20, BYTE, 1, 32'h00000099, 0, 0, 32'h0, 0);
        op("rd20c", 32'h20, WORD, 0, 32'h0, 0, 0, 32'hBEEF7799, 0);
        op("rdw11", 32'h11, WORD, 0, 32'h0, 0, 0, 32'h0, 1);
        op("rdd20", 32'h20, DWORD, 0, 32'h0, 0, 0, 32'h0, 1);
        op("rdq20", 32'h20, QWORD, 0, 32'h0, 0, 0, 32'h0, 1);
        op("rdtop", TOP, WORD, 0, 32'h0, 0, 0, 32'h0, 1);
        op("wrtop", TOP, WORD, 1, 32'h12345678, 0, 0, 32'h0, 1);
        op("wrlast", TOP - 4, WORD, 1, 32'hA5A50F0F, 0, 0, 32'h0, 0);
        op("rdlast", TOP - 4, WORD, 0, 32'h0, 0, 0, 32'hA5A50F0F, 0);
        op("rdchg", 32'h10, WORD, 0, 32'h0, 0, 1, 32'h11AA3344, 0);
        op("rd20d", 32'h20, WORD, 0, 32'h0, 0, 0, 32'hBEEF7799, 0);

        op("wr30", 32'h30, WORD, 1, 32'hCAFEF00D, 1, 0, 32'h0, 0);
        check("lock.set", {31'b0, plocked_o}, 32'h1);

        padr_i  = 32'h30;
        psize_i = WORD;
        pwe_i   = 1'b1;
        pd_i    = 32'h12345678;
        plock_i = 1'b0;
        preq_i  = 1'b1;
        @(posedge clk_i);
        @(negedge clk_i);
        check("mid.busy", {31'b0, busy_o}, 32'h1);
        rst_i  = 1'b1;
        preq_i = 1'b0;
        @(negedge clk_i);
        check("mid.plocked", {31'b0, plocked_o}, 32'h0);
        rst_i = 1'b0;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk_i);
            if (pack_o) seen++;
        end
        check("mid.nopack", 32'(seen), 32'h0);
        wait_idle("mid");
        op("rd30", 32'h30, WORD, 0, 32'h0, 0, 0,
           CLR ? 32'h0 : 32'hCAFEF00D, 0);

`ifdef RV_MEMRESP_CLEAR_EN
        rst_i = 1'b1;
        @(negedge clk_i);
        rst_i = 1'b0;
        xact(32'h10, WORD, 0, 32'h0, 0, 0, q, err, lat);
        check("clrreq.lat", 32'(lat), 32'(DEPTH + WS + 1));
        check("clrreq.pq", q, 32'h0);
        check("clrreq.perr", {31'b0, err}, 32'h0);
        op("clr.rd3c", 32'h3C, WORD, 0, 32'h0, 0, 0, 32'h0, 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
